// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver of the link.
package uart_pkg;

    localparam int         FRAME_BITS  = 10;
    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam int         BPS_DEFAULT = 5208;
    localparam logic [3:0] LAST_BIT    = 4'(FRAME_BITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Line level of frame bit idx: start, eight data bits LSB first, then stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
        logic bit_s;
        case (idx)
            4'd0:                                   bit_s = START_BIT;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:                 bit_s = data[3'(idx - 4'd1)];
            default:                                bit_s = STOP_BIT;
        endcase
        return bit_s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO for the UART transmitter; wrap-bit pointers, registered flags.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [AW:0]      wptr_nxt_s;
    logic [AW:0]      rptr_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             full_nxt_s;
    logic             empty_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests and derive next pointers and the flags they imply.
    always_comb begin
        do_push_s = push && !full_r;
        do_pop_s  = pop && !empty_r;
        if (do_push_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (do_pop_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
        full_nxt_s  = (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]) && (wptr_nxt_s[AW] != rptr_nxt_s[AW]);
        empty_nxt_s = (wptr_nxt_s == rptr_nxt_s);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            full_r  <= full_nxt_s;
            empty_r <= empty_nxt_s;
        end
    end

    // Storage write port; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop shifter at BPS clocks per bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BPS        = BPS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       rdy,
    output logic       dout,
    output logic       busy
);

    localparam logic [15:0] CNT0_LAST = 16'(BPS - 1);

    tx_state_e   state_r;
    logic [15:0] cnt0_r;
    logic [3:0]  cnt1_r;
    logic [7:0]  sr_r;
    logic        dout_r;
    logic        busy_r;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic        bit_end_s;
    logic [7:0]  head_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (din),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign push_s = din_vld && !full_s;

    // Pop the head when a frame starts from idle or back-to-back at the end of a stop bit.
    always_comb begin
        bit_end_s = (cnt0_r == CNT0_LAST);
        if (state_r == ST_IDLE) begin
            pop_s = !empty_s;
        end else if (bit_end_s && (cnt1_r == LAST_BIT)) begin
            pop_s = !empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Transmit FSM with bit timing, shift register and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt0_r  <= 16'd0;
            cnt1_r  <= 4'd0;
            sr_r    <= 8'h00;
            dout_r  <= STOP_BIT;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt0_r <= 16'd0;
                    cnt1_r <= 4'd0;
                    if (!empty_s) begin
                        state_r <= ST_SEND;
                        sr_r    <= head_s;
                        dout_r  <= START_BIT;
                        busy_r  <= 1'b1;
                    end else begin
                        dout_r  <= STOP_BIT;
                        busy_r  <= push_s;
                    end
                end
                ST_SEND: begin
                    if (!bit_end_s) begin
                        cnt0_r <= cnt0_r + 16'd1;
                        busy_r <= 1'b1;
                    end else if (cnt1_r != LAST_BIT) begin
                        cnt0_r <= 16'd0;
                        cnt1_r <= cnt1_r + 4'd1;
                        dout_r <= frame_bit(cnt1_r + 4'd1, sr_r);
                        busy_r <= 1'b1;
                    end else if (!empty_s) begin
                        // Next start bit follows the stop bit with no idle gap.
                        cnt0_r <= 16'd0;
                        cnt1_r <= 4'd0;
                        sr_r   <= head_s;
                        dout_r <= START_BIT;
                        busy_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt0_r  <= 16'd0;
                        cnt1_r  <= 4'd0;
                        dout_r  <= STOP_BIT;
                        busy_r  <= push_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt0_r  <= 16'd0;
                    cnt1_r  <= 4'd0;
                    dout_r  <= STOP_BIT;
                    busy_r  <= push_s || !empty_s;
                end
            endcase
        end
    end

    assign rdy  = !full_s;
    assign dout = dout_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: queue-based line model, loopback decoder, directed and random traffic.
module tb_uart_tx;

    localparam int BPS   = 16;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] din     = 8'h00;
    logic       din_vld = 1'b0;
    logic       rdy;
    logic       dout;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    uart_tx #(.BPS(BPS), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_vld (din_vld),
        .rdy     (rdy),
        .dout    (dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending bytes plus a per-cycle queue of line levels still to be shown.
    logic [7:0] m_fifo[$];
    bit         m_line[$];
    logic [7:0] exp_tx[$];
    bit         exp_dout = 1'b1;
    bit         exp_rdy  = 1'b1;
    bit         exp_busy = 1'b0;
    int         rst_gen  = 0;

    always @(posedge clk) begin : model
        logic [7:0] b;
        bit         acc;
        bit         in_frame;
        if (rst) begin
            if (m_line.size() != 0 && exp_tx.size() != 0) void'(exp_tx.pop_back());
            m_fifo.delete();
            m_line.delete();
            exp_dout = 1'b1;
            exp_rdy  = 1'b1;
            exp_busy = 1'b0;
            rst_gen++;
        end else begin
            acc = din_vld && (m_fifo.size() < DEPTH);
            if (m_line.size() == 0 && m_fifo.size() != 0) begin
                b = m_fifo.pop_front();
                exp_tx.push_back(b);
                for (int i = 0; i < 10; i++)
                    for (int c = 0; c < BPS; c++)
                        m_line.push_back(i == 0 ? 1'b0 : (i == 9 ? 1'b1 : b[i-1]));
            end
            in_frame = (m_line.size() != 0);
            exp_dout = in_frame ? m_line.pop_front() : 1'b1;
            if (acc) m_fifo.push_back(din);
            exp_rdy  = (m_fifo.size() < DEPTH);
            exp_busy = in_frame || (m_fifo.size() != 0);
        end
    end

    // Loopback receiver sampling at mid-bit.
    logic [7:0] rx_hist[$];
    bit         rx_stop_hist[$];
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_gen    = 0;
    int         rx_k      = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(negedge clk) begin : loopback_rx
        if (rx_gen != rst_gen) begin
            rx_gen    = rst_gen;
            rx_active = 1'b0;
        end
        if (!rx_active) begin
            if (dout === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BPS == BPS / 2) begin
                rx_k = rx_cnt / BPS;
                if (rx_k >= 1 && rx_k <= 8) begin
                    rx_byte[rx_k-1] = dout;
                end else if (rx_k == 9) begin
                    rx_hist.push_back(rx_byte);
                    rx_stop_hist.push_back(dout);
                    rx_active = 1'b0;
                end
            end
        end
    end

    int rx_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: land on the falling edge, then compare outputs and decoded bytes.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("rdy", 32'(rdy), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(exp_busy));
            while (rx_seen < rx_hist.size()) begin
                if (rx_seen < exp_tx.size()) chk("rx_order", 32'(rx_hist[rx_seen]), 32'(exp_tx[rx_seen]));
                else chk("rx_extra", 32'(rx_hist.size()), 32'(exp_tx.size()));
                chk("rx_stop", 32'(rx_stop_hist[rx_seen]), 32'd1);
                rx_seen++;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output int acc_cyc);
        bit r;
        int n;
        n       = 0;
        din     = b;
        din_vld = 1'b1;
        do begin
            r = rdy;
            step();
            n++;
        end while (!r && n < 1000);
        chk("accept", 32'(r), 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n       = 0;
        din_vld = 1'b0;
        while ((busy !== 1'b0 || exp_busy) && n < 3000) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_rx(input string name, input int h0, input logic [7:0] want[$]);
        chk({name, "_count"}, 32'(rx_hist.size() - h0), 32'(want.size()));
        for (int i = 0; i < want.size() && h0 + i < rx_hist.size(); i++)
            chk(name, 32'(rx_hist[h0+i]), 32'(want[i]));
    endtask

    initial begin : stim
        int         c0;
        int         c1;
        int         h0;
        int         zeros;
        int         acc[6];
        logic [7:0] six[6];
        logic [7:0] want[$];
        logic [9:0] a5_frame;

        // Reset and idle
        rst = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_dout", 32'(dout), 32'd1);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_dout", 32'(dout), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single 0xA5 against a hand-written frame
        a5_frame = 10'b1101001010;
        h0       = rx_hist.size();
        din      = 8'hA5;
        din_vld  = 1'b1;
        step();
        din_vld  = 1'b0;
        chk("a5_busy_e0", 32'(busy), 32'd1);
        chk("a5_dout_e0", 32'(dout), 32'd1);
        for (int k = 1; k <= 160; k++) begin
            step();
            chk("a5_bit", 32'(dout), 32'(a5_frame[(k-1)/BPS]));
        end
        chk("a5_busy_last", 32'(busy), 32'd1);
        step();
        chk("a5_busy_fall", 32'(busy), 32'd0);
        chk("a5_dout_idle", 32'(dout), 32'd1);
        want = '{8'hA5};
        check_rx("a5_rx", h0, want);

        // Back-to-back frames
        h0 = rx_hist.size();
        push_byte(8'h00, c0);
        push_byte(8'hFF, c1);
        push_byte(8'h55, c1);
        wait_idle();
        chk("b2b_duration", 32'(cyc - c0), 32'd481);
        repeat (2) step();
        want = '{8'h00, 8'hFF, 8'h55};
        check_rx("b2b_rx", h0, want);

        // Six bytes into a four-deep FIFO with din_vld held
        six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
        h0  = rx_hist.size();
        for (int i = 0; i < 6; i++) begin
            push_byte(six[i], acc[i]);
            if (i == 4) chk("full_rdy_low", 32'(rdy), 32'd0);
        end
        din_vld = 1'b0;
        chk("acc_fifth", 32'(acc[4] - acc[0]), 32'd4);
        chk("acc_sixth", 32'(acc[5] - acc[0]), 32'd162);
        wait_idle();
        chk("six_duration", 32'(cyc - acc[0]), 32'd961);
        repeat (2) step();
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
        check_rx("six_rx", h0, want);

        // Reset during data bit 3 of 0x3C with two bytes queued
        h0 = rx_hist.size();
        push_byte(8'h3C, c0);
        push_byte(8'h11, c1);
        push_byte(8'h22, c1);
        din_vld = 1'b0;
        while (cyc < c0 + 70) step();
        chk("bit3_of_3c", 32'(dout), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_dout", 32'(dout), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdy", 32'(rdy), 32'd1);
        zeros = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (dout !== 1'b1) zeros++;
        end
        chk("midrst_silent", 32'(zeros), 32'd0);
        want.delete();
        check_rx("midrst_rx", h0, want);

        // Push on the same edge as the end-of-frame pop
        h0 = rx_hist.size();
        push_byte(8'h5A, c0);
        din_vld = 1'b0;
        repeat (20) step();
        push_byte(8'hC3, c1);
        din_vld = 1'b0;
        while (cyc < c0 + 160) step();
        push_byte(8'h96, c1);
        din_vld = 1'b0;
        chk("eof_push_edge", 32'(c1 - c0), 32'd161);
        chk("eof_rdy", 32'(rdy), 32'd1);
        chk("eof_busy", 32'(busy), 32'd1);
        chk("eof_start", 32'(dout), 32'd0);
        wait_idle();
        chk("eof_duration", 32'(cyc - c0), 32'd481);
        repeat (2) step();
        want = '{8'h5A, 8'hC3, 8'h96};
        check_rx("eof_rx", h0, want);

        // Random traffic: alternating sparse and heavy phases
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1000; i++) begin
                din_vld = ($urandom_range(0, 99) < ((p % 2 == 0) ? 1 : 40));
                din     = 8'($urandom);
                step();
            end
        end
        wait_idle();
        repeat (2) step();
        chk("rand_all_rx", 32'(rx_seen), 32'(exp_tx.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts bytes on a valid/ready handshake, buffers them in a small FIFO and shifts each out as an 8N1 frame (start 0, 8 data bits LSB first, stop 1) at a fixed clocks-per-bit rate. It is the transmit end of the UART link whose receiver samples at mid-bit with the same `BPS` divisor. In the temperature-monitor design it drives the board TX pin with readings and status bytes formatted upstream.

## Interface

- `BPS`, 5208: clocks per bit period, 50 MHz / 9600 baud. Legal range 2..65535.
- `FIFO_DEPTH`, 4: byte buffer depth. Power of two, at least 2.

Ports:

- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous, active-high.
- `din` input 8: byte to send.
- `din_vld` input 1: `din` is valid this cycle.
- `rdy` output 1: FIFO can accept a byte. Equal to not-full. Reset 1.
- `dout` output 1: serial line, registered. Idles high. Reset 1.
- `busy` output 1: a frame is in progress, or the FIFO is non-empty. Reset 0.

## Operation

- Accept: a byte is written when `din_vld && rdy` at a rising edge. `din_vld` while `rdy` is 0 is ignored; the byte is dropped and the FIFO is unchanged.
- FIFO:
  - Write and read pointers are `log2(FIFO_DEPTH)+1` bits; the MSB is the wrap bit.
  - Full: addresses equal and wrap bits differ. Empty: pointers equal.
  - Simultaneous push and pop is legal whenever not full; the count is unchanged.
- FSM states:
  - IDLE: `dout`=1. Move to SEND and pop the FIFO head into shift register `sr` when the FIFO is non-empty.
  - SEND: bit counter `cnt1` runs 0..9. Bit 0 is the start bit (0), bits 1..8 are `sr[0..7]`, bit 9 is the stop bit (1).
- Clock counter `cnt0` runs 0..BPS-1 while in SEND.
  - End of bit: `cnt0==BPS-1`. Advances `cnt1`.
  - End of frame: end of bit with `cnt1==9`.
- End of frame with FIFO non-empty: pop immediately and stay in SEND, so the next start bit follows the stop bit with no idle gap.
- End of frame with FIFO empty: go to IDLE.
- `dout` is registered from state, `cnt1` and `sr`. Never glitches mid-bit.
- Widths:
  - `cnt0` is 16 bits.
  - `cnt1` is 4 bits; values above 9 are unreachable.
  - `din` is captured whole; no parity.
- Reset at any time, including mid-frame, on the next edge:
  - `dout`=1, state IDLE, counters 0, FIFO pointers 0.
  - `rdy`=1, `busy`=0.
  - Any partial frame is abandoned.

## Timing

- Write at edge E0 into an empty FIFO while IDLE: `busy`=1 after E0. Pop at E1; `dout`=0 after E1, i.e. one cycle of latency.
- Each bit is held exactly `BPS` cycles; a frame is `10*BPS` cycles.
- `rdy` falls the cycle after the write that fills the FIFO. It rises the cycle after the pop that frees a slot.
- `busy` falls after the end-of-frame edge when the FIFO is empty, coincident with `dout` returning to IDLE high.

## Structure

- Shared package/header `uart_pkg`:
  - Frame constants: `FRAME_BITS`=10, `START_BIT`=0, `STOP_BIT`=1.
  - Default `BPS`.
  - The receiver uses the same package.
- One sub-module, `uart_tx_fifo`. Synchronous, parameterised by depth. Ports: push, pop, wdata, rdata (show-ahead), full, empty.
- The top holds the FSM, `cnt0`/`cnt1` and `sr`.

## Test plan

Run with `BPS`=16.

- Reset, then idle for 100 cycles: `dout`=1, `rdy`=1, `busy`=0 throughout.
- Send a single 0xA5: `dout`=0 for 16 cycles starting one cycle after the accept, then 1,0,1,0,0,1,0,1 for 16 cycles each, then stop 1. `busy` falls after 160 cycles.
- Push 0x00, 0xFF, 0x55 back-to-back: three contiguous frames with no idle cycle between a stop bit and the next start bit. A loopback `uart_rx` with `BPS`=16 reports the same three bytes in order.
- Push 6 bytes consecutively with `FIFO_DEPTH`=4:
  - `rdy` drops after the FIFO fills (first byte popped, four buffered).
  - The 6th byte with `din_vld` held is accepted only after the first frame completes.
  - No byte is lost or duplicated.
- Assert `rst` during data bit 3 of 0x3C with two bytes queued: `dout`=1, `busy`=0 and `rdy`=1 on the next cycle. No further frames are emitted.
- Push at the same edge as the end-of-frame pop: the FIFO count is unchanged and the frame order is preserved.
